// File: rtl/countdown_ctrl.sv
// Control stage for the 4-digit BCD countdown counter: turns start/stop and clear
// pulses into count ticks (en) and load strobes (clr), and blinks an alarm on expiry.
module countdown_ctrl #(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned BLINK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic start_stop,
  input  logic clear,
  input  logic zero,
  output logic en,
  output logic clr,
  output logic running,
  output logic alarm
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned BW = $clog2(BLINK_DIV) + 1;
  localparam logic [PW-1:0] TickLast  = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BlinkLast = BW'(BLINK_DIV - 1);

  typedef enum logic [2:0] {StLoad, StIdle, StRun, StPause, StAlarm} state_e;

  state_e        r_state, w_state_d;
  logic [PW-1:0] r_presc, w_presc_d;
  logic [BW-1:0] r_blink, w_blink_d;
  logic          r_en, w_en_d;
  logic          r_clr, w_clr_d;
  logic          r_running, w_running_d;
  logic          r_alarm, w_alarm_d;

  logic w_stay_run;
  logic w_keep_presc;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StLoad;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic; priority is clear > zero > start_stop in every state.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StLoad: w_state_d = StIdle;
      StIdle: begin
        if (clear)                    w_state_d = StLoad;
        else if (start_stop && !zero) w_state_d = StRun;
      end
      StRun: begin
        if (clear)           w_state_d = StLoad;
        else if (zero)       w_state_d = StAlarm;
        else if (start_stop) w_state_d = StPause;
      end
      StPause: begin
        if (clear)           w_state_d = StLoad;
        else if (zero)       w_state_d = StAlarm;
        else if (start_stop) w_state_d = StRun;
      end
      StAlarm: begin
        if (clear)           w_state_d = StLoad;
        else if (start_stop) w_state_d = StIdle;
      end
      default: w_state_d = StLoad;
    endcase
  end

  // Output and counter next values, all computed for registering.
  always_comb begin
    w_stay_run   = (r_state == StRun) && (w_state_d == StRun);
    // Prescaler survives RUN<->PAUSE so a paused tick period resumes where it stopped.
    w_keep_presc = ((r_state == StRun) || (r_state == StPause)) &&
                   ((w_state_d == StRun) || (w_state_d == StPause));

    w_presc_d = '0;
    if (w_stay_run) begin
      w_presc_d = (r_presc == TickLast) ? '0 : r_presc + PW'(1);
    end else if (w_keep_presc) begin
      w_presc_d = r_presc;
    end

    w_en_d      = w_stay_run && (r_presc == TickLast);
    w_clr_d     = (w_state_d == StLoad);
    w_running_d = (w_state_d == StRun);

    w_blink_d = '0;
    w_alarm_d = 1'b0;
    if ((r_state == StAlarm) && (w_state_d == StAlarm)) begin
      if (r_blink == BlinkLast) begin
        w_blink_d = '0;
        w_alarm_d = ~r_alarm;
      end else begin
        w_blink_d = r_blink + BW'(1);
        w_alarm_d = r_alarm;
      end
    end else if (w_state_d == StAlarm) begin
      w_alarm_d = 1'b1;
    end
  end

  // Output and counter registers; clr resets high because reset lands in LOAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc   <= '0;
      r_blink   <= '0;
      r_en      <= 1'b0;
      r_clr     <= 1'b1;
      r_running <= 1'b0;
      r_alarm   <= 1'b0;
    end else begin
      r_presc   <= w_presc_d;
      r_blink   <= w_blink_d;
      r_en      <= w_en_d;
      r_clr     <= w_clr_d;
      r_running <= w_running_d;
      r_alarm   <= w_alarm_d;
    end
  end

  assign en      = r_en;
  assign clr     = r_clr;
  assign running = r_running;
  assign alarm   = r_alarm;

endmodule
